key_entry_sequencer: RTL
========================

# key_entry_sequencer

Sequences keypad code entry for the alarm controller. Collects a fixed-length code from the keyboard link (2-bit digits qualified by a receive strobe), compares it against the armed code, and reports one result pulse to the main state machine on the existing KEY_STATUS encoding. It adds an inter-digit timeout and a brute-force lockout. It sits between the keyboard receive pins and the main FSM, in the same clock domain as the low-frequency oscillator (~10 kHz).

## Interface
- CODE_LEN, 4: digits per code (2..7).
- DIGIT_TIMEOUT, 18'd50000: cycles allowed after an accepted digit before a partial entry is abandoned (≥1).
- LOCK_CYCLES, 18'd200000: lockout duration in cycles (≥1).
- MAX_FAILS, 3: consecutive wrong codes that trigger lockout (1..7).
- CLK  in  1  system clock (oscillator output).
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low.
- KB_IN  in  2  keypad digit; valid while KB_RECV is high.
- KB_RECV  in  1  digit strobe from the keyboard chip; asynchronous.
- VALID_KEY  in  2*CODE_LEN  armed code; the first digit is the MSB pair; static during entry.
- KEY_STATUS  out  2  0=KEY_OK, 1=KEY_TIMEOUT, 2=KEY_ERROR, 3=NO_KEY.
- LOCKED  out  1  high during lockout.
- ENTRY_ACTIVE  out  1  high while a partial code is held.
- DIGIT_COUNT  out  3  number of digits held.

## Operation
- Reset values: KEY_STATUS=3 (NO_KEY), LOCKED=0, ENTRY_ACTIVE=0, DIGIT_COUNT=0, fail count 0, synchronizers 0, FSM=IDLE.
- Input sync:
  - KB_RECV and KB_IN each pass through two flops (s1, s2).
  - A third flop s3 holds the previous s2 of KB_RECV.
  - Strobe event = s2 & !s3. The digit is the synchronized KB_IN at s2.
  - Edge tracking runs in every state, so a strobe held high across state changes yields no event.
- FSM states: IDLE, COLLECT, LOCKOUT.
  - IDLE, strobe event: store the digit at position 0, DIGIT_COUNT=1, load the timeout counter, go to COLLECT. If CODE_LEN would be reached immediately, the final-digit rule applies.
  - COLLECT, strobe event, not final: shift the digit in, increment DIGIT_COUNT, reload the timeout counter.
  - COLLECT, final digit (count reaches CODE_LEN): compare all CODE_LEN digits, including the incoming one, against VALID_KEY.
    - Match: KEY_STATUS=0, fail count cleared, go to IDLE.
    - Mismatch: KEY_STATUS=2, fail count +1 (saturating at MAX_FAILS). If the count reaches MAX_FAILS, go to LOCKOUT and set LOCKED on the same edge; otherwise go to IDLE.
    - In both cases DIGIT_COUNT and the digit store are cleared.
  - COLLECT, timeout counter expires with no event: KEY_STATUS=1, clear the digits, go to IDLE. The fail count is unchanged.
  - LOCKOUT: strobe events are discarded and KEY_STATUS stays 3. After LOCK_CYCLES cycles: LOCKED=0, fail count cleared, go to IDLE.
- KEY_STATUS is a registered one-cycle pulse. It returns to 3 on the next edge unconditionally.
- ENTRY_ACTIVE = (state==COLLECT).
- Simultaneous events:
  - A strobe event on the timeout-expiry edge is accepted and the timeout is not reported.
  - A strobe event on the lockout-exit edge is discarded.
- Async reset mid-entry or mid-lockout: all state is cleared immediately, and no result is reported.
- Width rules: timeout and lock counters are 18-bit down-counters; DIGIT_COUNT is 3 bits; the fail counter is 3 bits and saturating.

## Timing
- KB_RECV first sampled high at edge k: s2 high after edge k+1, digit accepted at edge k+2. For the final digit, KEY_STATUS holds the result from edge k+2 to edge k+3.
- Minimum KB_RECV high and low widths: 2 cycles each. Strobes closer than 3 cycles may merge.
- Timeout: a digit accepted at edge t with no event at edges t+1..t+DIGIT_TIMEOUT gives KEY_STATUS=1 at edge t+DIGIT_TIMEOUT.
- Lockout entered at edge L: LOCKED=1 from L to L+LOCK_CYCLES, exactly LOCK_CYCLES cycles. Events are accepted from edge L+LOCK_CYCLES+1.
- No combinational path from inputs to outputs.

## Test plan
Bench parameters: CODE_LEN=4, DIGIT_TIMEOUT=20, LOCK_CYCLES=50, MAX_FAILS=3, VALID_KEY=8'b00_01_10_11.
- Correct code: strobes with digits 0,1,2,3, 5 cycles apart -> DIGIT_COUNT steps 1..3; KEY_STATUS=0 for exactly one cycle, 2 cycles after the 4th strobe is sampled high; then ENTRY_ACTIVE=0 and KEY_STATUS=3.
- Wrong code: 0,1,2,2 -> KEY_STATUS=2 for one cycle; LOCKED=0; a following correct code -> KEY_STATUS=0, fail count cleared.
- Lockout: three wrong codes -> third report KEY_STATUS=2 with LOCKED=1 on the same edge; a correct code entered during lockout -> no KEY_STATUS pulse; LOCKED stays high exactly 50 cycles; a correct code afterwards -> KEY_STATUS=0.
- Timeout: digits 0,1 then silence -> KEY_STATUS=1 exactly 20 cycles after the 2nd digit is accepted; DIGIT_COUNT=0. In a second run the 3rd digit lands on the expiry edge -> no timeout; DIGIT_COUNT=3.
- Reset mid-entry: 3 digits, then RST_N low for 1 cycle mid-cycle -> outputs at reset values immediately; no KEY_STATUS pulse; the next full correct code -> KEY_STATUS=0.
- Held strobe: KB_RECV held high across lockout exit -> no digit accepted; the next low-to-high transition -> DIGIT_COUNT=1.

Source files
------------

// File: rtl/key_entry_sequencer.sv
// key_entry_sequencer
//
// Collects a fixed-length keypad code from the keyboard link and compares it
// against the armed code. It reports one result pulse per entry on the
// KEY_STATUS encoding. It also provides an inter-digit timeout and a lockout
// after too many consecutive wrong codes.
//
// Ports:
//   CLK          system clock (low-frequency oscillator)
//   RST_N        asynchronous active-low reset
//   KB_IN[1:0]   keypad digit, valid while KB_RECV is high (asynchronous)
//   KB_RECV      digit strobe from the keyboard chip (asynchronous)
//   VALID_KEY    armed code, first digit in the MSB pair
//   KEY_STATUS   one-cycle result: 0=OK, 1=TIMEOUT, 2=ERROR, 3=NO_KEY (idle)
//   LOCKED       high during lockout
//   ENTRY_ACTIVE high while a partial code is held
//   DIGIT_COUNT  number of digits held
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no digits held, waiting for the first strobe
// COLLECT | partial code held, inter-digit timer running
// LOCKOUT | too many wrong codes, strobes ignored until lock timer ends
module key_entry_sequencer #(
    parameter int unsigned CODE_LEN      = 4,
    parameter logic [17:0] DIGIT_TIMEOUT = 18'd50000,
    parameter logic [17:0] LOCK_CYCLES   = 18'd200000,
    parameter int unsigned MAX_FAILS     = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [1:0]            KB_IN,
    input  logic                  KB_RECV,
    input  logic [2*CODE_LEN-1:0] VALID_KEY,
    output logic [1:0]            KEY_STATUS,
    output logic                  LOCKED,
    output logic                  ENTRY_ACTIVE,
    output logic [2:0]            DIGIT_COUNT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    localparam logic [1:0]  KEY_OK      = 2'd0;
    localparam logic [1:0]  KEY_TIMEOUT = 2'd1;
    localparam logic [1:0]  KEY_ERROR   = 2'd2;
    localparam logic [1:0]  NO_KEY      = 2'd3;
    localparam int unsigned KEY_W       = 2 * CODE_LEN;
    localparam logic [2:0]  CODE_LEN_C  = 3'(CODE_LEN);
    localparam logic [2:0]  MAX_FAILS_C = 3'(MAX_FAILS);

    logic             recv_s1, recv_s2, recv_s3;
    logic [1:0]       kb_s1, kb_s2;
    state_t           state_q;
    logic [KEY_W-1:0] digits_q;
    logic [17:0]      timer_q;
    logic [17:0]      lock_q;
    logic [2:0]       fail_q;

    logic             strobe;
    logic [KEY_W-1:0] digits_next;
    logic [2:0]       count_inc;
    logic [2:0]       fail_inc;
    logic             final_digit;

    // Synchronizers and edge tracking run in every state, so a strobe that
    // rose during lockout cannot produce an event when lockout ends.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            recv_s1 <= 1'b0;
            recv_s2 <= 1'b0;
            recv_s3 <= 1'b0;
            kb_s1   <= 2'd0;
            kb_s2   <= 2'd0;
        end else begin
            recv_s1 <= KB_RECV;
            recv_s2 <= recv_s1;
            recv_s3 <= recv_s2;
            kb_s1   <= KB_IN;
            kb_s2   <= kb_s1;
        end
    end

    assign strobe      = recv_s2 & ~recv_s3;
    // The newest digit enters at the LSB pair, so after CODE_LEN digits the
    // first one sits in the MSB pair, matching VALID_KEY.
    assign digits_next = {digits_q[KEY_W-3:0], kb_s2};
    assign count_inc   = DIGIT_COUNT + 3'd1;
    assign final_digit = (count_inc == CODE_LEN_C);
    assign fail_inc    = (fail_q >= MAX_FAILS_C) ? MAX_FAILS_C : fail_q + 3'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            digits_q     <= '0;
            timer_q      <= '0;
            lock_q       <= '0;
            fail_q       <= 3'd0;
            KEY_STATUS   <= NO_KEY;
            LOCKED       <= 1'b0;
            ENTRY_ACTIVE <= 1'b0;
            DIGIT_COUNT  <= 3'd0;
        end else begin
            KEY_STATUS <= NO_KEY;
            case (state_q)
                IDLE, COLLECT: begin
                    // A strobe wins over a timer expiring on the same edge.
                    if (strobe) begin
                        if (final_digit) begin
                            digits_q     <= '0;
                            DIGIT_COUNT  <= 3'd0;
                            ENTRY_ACTIVE <= 1'b0;
                            state_q      <= IDLE;
                            if (digits_next == VALID_KEY) begin
                                KEY_STATUS <= KEY_OK;
                                fail_q     <= 3'd0;
                            end else begin
                                KEY_STATUS <= KEY_ERROR;
                                fail_q     <= fail_inc;
                                if (fail_inc == MAX_FAILS_C) begin
                                    state_q <= LOCKOUT;
                                    LOCKED  <= 1'b1;
                                    lock_q  <= LOCK_CYCLES - 18'd1;
                                end
                            end
                        end else begin
                            digits_q     <= digits_next;
                            DIGIT_COUNT  <= count_inc;
                            ENTRY_ACTIVE <= 1'b1;
                            timer_q      <= DIGIT_TIMEOUT - 18'd1;
                            state_q      <= COLLECT;
                        end
                    end else if (state_q == COLLECT) begin
                        if (timer_q == 18'd0) begin
                            KEY_STATUS   <= KEY_TIMEOUT;
                            digits_q     <= '0;
                            DIGIT_COUNT  <= 3'd0;
                            ENTRY_ACTIVE <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            timer_q <= timer_q - 18'd1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (lock_q == 18'd0) begin
                        LOCKED  <= 1'b0;
                        fail_q  <= 3'd0;
                        state_q <= IDLE;
                    end else begin
                        lock_q <= lock_q - 18'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
